// File: rtl/phase_timer.sv
// phase_timer: loadable countdown of traffic-phase durations on enable_1Hz ticks.
// It supports one-shot or periodic reload, hold, abort and a near-expiry warning.
// Defining PHASE_TIMER_EXTEND_EN adds the extend/extend_value ports, which add time to a live count.
module phase_timer #(
    parameter int WIDTH       = 4,
    parameter int WARN_THRESH = 3,
    parameter int MAX_COUNT   = (2**WIDTH)-1
) (
    input  logic             clk,
    input  logic             reset_global,
    input  logic             enable_1Hz,
    input  logic             start_timer,
    input  logic [WIDTH-1:0] time_param_output_value,
    input  logic             mode_periodic,
    input  logic             pause,
    input  logic             abort,
`ifdef PHASE_TIMER_EXTEND_EN
    input  logic             extend,
    input  logic [WIDTH-1:0] extend_value,
`endif
    output logic             expired,
    output logic             running,
    output logic [WIDTH-1:0] remaining,
    output logic             warning
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [WIDTH:0] MAX_C  = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] WARN_C = (WIDTH+1)'(WARN_THRESH);

    state_t           state_q;
    logic [WIDTH-1:0] remaining_q;
    logic [WIDTH-1:0] reload_q;
    logic             mode_q;
    logic             expired_q;

    logic             ext_req_d;
    logic [WIDTH-1:0] ext_val_d;

`ifdef PHASE_TIMER_EXTEND_EN
    logic [WIDTH:0]   ext_sum_d;

    // Sum is one bit wider so the saturation compare sees the true overflow.
    assign ext_sum_d = {1'b0, remaining_q} + {1'b0, extend_value};
    assign ext_req_d = extend && (state_q != IDLE);
    assign ext_val_d = (ext_sum_d > MAX_C) ? MAX_C[WIDTH-1:0] : ext_sum_d[WIDTH-1:0];
`else
    assign ext_req_d = 1'b0;
    assign ext_val_d = remaining_q;
`endif

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            reload_q    <= '0;
            mode_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                remaining_q <= '0;
            end else if (start_timer) begin
                reload_q    <= time_param_output_value;
                remaining_q <= time_param_output_value;
                mode_q      <= mode_periodic;
                if (time_param_output_value == '0) begin
                    state_q   <= IDLE;
                    expired_q <= 1'b1;
                end else begin
                    state_q <= RUN;
                end
            end else if (ext_req_d) begin
                remaining_q <= ext_val_d;
            end else begin
                case (state_q)
                    RUN: begin
                        if (pause) begin
                            state_q <= HOLD;
                        end else if (enable_1Hz) begin
                            if (remaining_q > WIDTH'(1)) begin
                                remaining_q <= remaining_q - WIDTH'(1);
                            end else begin
                                expired_q <= 1'b1;
                                if (mode_q) begin
                                    remaining_q <= reload_q;
                                end else begin
                                    remaining_q <= '0;
                                    state_q     <= IDLE;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (!pause) state_q <= RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign expired   = expired_q;
    assign running   = (state_q != IDLE);
    assign remaining = remaining_q;
    assign warning   = running && (remaining_q != '0) && ({1'b0, remaining_q} <= WARN_C);

endmodule
